// File: rtl/rib_pkg.sv
// Shared constants and types for the RIB crossbar: bus widths, slave-select
// field position, arbiter state encoding and arbitration mode selectors.
package rib_pkg;

   localparam int ADDR_W      = 32;
   localparam int DATA_W      = 32;
   localparam int SLV_SEL_MSB = 31;
   localparam int SLV_SEL_LSB = 28;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rib_rr_arb.sv
// Request-to-one-hot arbiter: the first requester at or after ptr, searching
// upward modulo NUM_M, wins. A ptr tied to zero gives fixed priority.
module rib_rr_arb #(
   parameter int NUM_M = 4,
   parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
   input  logic [NUM_M-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NUM_M-1:0] gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   logic [IDX_W:0]   sum  [NUM_M];
   logic [IDX_W-1:0] cand [NUM_M];

   // cand[i] is the master index examined at search position i
   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_cand
         assign sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
         assign cand[gi] = (sum[gi] >= (IDX_W+1)'(NUM_M))
                         ? IDX_W'(sum[gi] - (IDX_W+1)'(NUM_M))
                         : sum[gi][IDX_W-1:0];
      end
   endgenerate

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = NUM_M - 1; i >= 0; i--) begin
         if (req[cand[i]]) begin
            idx   = cand[i];
            valid = 1'b1;
         end
      end
      if (valid) gnt[idx] = 1'b1;
   end

endmodule

// File: rtl/rib_xbar.sv
// NUM_M x NUM_S bus crossbar with a single shared grant, optional grant lock,
// zero-latency read return and decode-error capture.
module rib_xbar
   import rib_pkg::*;
#(
   parameter int NUM_M    = 4,
   parameter int NUM_S    = 6,
   parameter int ARB_MODE = 0,
   parameter int LOCK_EN  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_M*32-1:0] m_addr_i,
   input  logic [NUM_M*32-1:0] m_data_i,
   input  logic [NUM_M-1:0]    m_req_i,
   input  logic [NUM_M-1:0]    m_we_i,
   output logic [NUM_M*32-1:0] m_data_o,
   output logic [NUM_M-1:0]    m_gnt_o,
   output logic [NUM_M-1:0]    m_hold_o,
   output logic [NUM_S*32-1:0] s_addr_o,
   output logic [NUM_S*32-1:0] s_data_o,
   input  logic [NUM_S*32-1:0] s_data_i,
   output logic [NUM_S-1:0]    s_we_o,
   output logic                err_o,
   output logic [31:0]         err_addr_o,
   output logic [7:0]          err_cnt_o
);

   localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

   arb_state_t       state_reg, state_next;
   logic [IDX_W-1:0] owner_reg, owner_next;
   logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
   logic [31:0]      err_addr_reg;
   logic [7:0]       err_cnt_reg;

   logic [ADDR_W-1:0] m_addr [NUM_M];
   logic [DATA_W-1:0] m_wdat [NUM_M];
   logic [DATA_W-1:0] s_rdat [NUM_S];

   logic [NUM_M-1:0]  arb_gnt;
   logic [IDX_W-1:0]  arb_idx, arb_ptr;
   logic              arb_valid;
   logic              owner_active;
   logic [IDX_W-1:0]  grant_idx;
   logic              grant_valid;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic              g_we;
   logic [3:0]        sel;
   logic              dec_err;
   logic [DATA_W-1:0] rd_data;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_M; gi++) begin : g_m_unpack
         assign m_addr[gi] = m_addr_i[32*gi +: 32];
         assign m_wdat[gi] = m_data_i[32*gi +: 32];
      end
      for (gi = 0; gi < NUM_S; gi++) begin : g_s_unpack
         assign s_rdat[gi] = s_data_i[32*gi +: 32];
      end
   endgenerate

   assign arb_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_reg : '0;

   rib_rr_arb #(
      .NUM_M (NUM_M),
      .IDX_W (IDX_W)
   ) u_arb (
      .req   (m_req_i),
      .ptr   (arb_ptr),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // A live owner overrides the arbiter; once its req drops, the arbiter
   // result (which already excludes the old owner) takes over in the same cycle.
   assign owner_active = (LOCK_EN != 0) && (state_reg == OWNED) && m_req_i[owner_reg];
   assign grant_idx    = owner_active ? owner_reg : arb_idx;
   assign grant_valid  = !rst && (owner_active || arb_valid);

   always_comb begin
      m_gnt_o = '0;
      if (grant_valid) m_gnt_o[grant_idx] = 1'b1;
   end

   assign m_hold_o = m_req_i & ~m_gnt_o;

   assign g_addr  = grant_valid ? m_addr[grant_idx] : '0;
   assign g_data  = grant_valid ? m_wdat[grant_idx] : '0;
   assign g_we    = grant_valid & m_we_i[grant_idx];
   assign sel     = g_addr[SLV_SEL_MSB:SLV_SEL_LSB];
   assign dec_err = grant_valid && ({1'b0, sel} >= 5'(NUM_S));

   always_comb begin
      rd_data = '0;
      for (int j = 0; j < NUM_S; j++) begin
         if (sel == 4'(j)) rd_data = s_rdat[j];
      end
   end

   generate
      for (gi = 0; gi < NUM_S; gi++) begin : g_slave
         logic hit;
         assign hit                  = grant_valid && !dec_err && (sel == 4'(gi));
         assign s_addr_o[32*gi +: 32] = hit ? {4'h0, g_addr[SLV_SEL_LSB-1:0]} : '0;
         assign s_data_o[32*gi +: 32] = hit ? g_data : '0;
         assign s_we_o[gi]            = hit & g_we;
      end
      for (gi = 0; gi < NUM_M; gi++) begin : g_master
         assign m_data_o[32*gi +: 32] = (m_gnt_o[gi] && !dec_err) ? rd_data : '0;
      end
   endgenerate

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      if (!owner_active && arb_valid) begin
         owner_next = arb_idx;
         if (ARB_MODE == ARB_RR)
            rr_ptr_next = (arb_idx == IDX_W'(NUM_M - 1)) ? '0 : arb_idx + IDX_W'(1);
      end
      if (LOCK_EN == 0)
         state_next = IDLE;
      else if (owner_active || arb_valid)
         state_next = OWNED;
      else
         state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         owner_reg    <= '0;
         rr_ptr_reg   <= '0;
         err_addr_reg <= '0;
         err_cnt_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         rr_ptr_reg <= rr_ptr_next;
         if (dec_err) begin
            err_addr_reg <= g_addr;
            if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
         end
      end
   end

   assign err_o      = dec_err;
   assign err_addr_o = err_addr_reg;
   assign err_cnt_o  = err_cnt_reg;

endmodule
